// File: rtl/formation_motion_ctrl.sv
// Formation motion controller: start delay, then sway right / descend / sway left / descend
// until the vertical limit would be exceeded, producing per-frame velocities and offsets.
module formation_motion_ctrl #(
    parameter int StartDelay    = 60,
    parameter int SwaySpeed     = 1,
    parameter int XLimit        = 40,
    parameter int DescendFrames = 8,
    parameter int DescendSpeed  = 1,
    parameter int YLimit        = 160
) (
    input  logic       frame_clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    output logic [9:0] xvel_o,
    output logic [9:0] yvel_o,
    output logic [9:0] xoff_o,
    output logic [9:0] yoff_o,
    output logic [2:0] state_o,
    output logic       bottom_o
);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_RIGHT = 3'd1,
        ST_LEFT  = 3'd2,
        ST_DOWN  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [15:0]        START_LAST  = 16'(StartDelay - 1);
    localparam logic [15:0]        DESC_LAST   = 16'(DescendFrames);
    localparam logic signed [10:0] SWAY_S      = 11'(SwaySpeed);
    localparam logic signed [10:0] XLIM_POS_S  = 11'(XLimit);
    localparam logic signed [10:0] XLIM_NEG_S  = -11'(XLimit);
    localparam logic [10:0]        YLIM_U      = 11'(YLimit);
    localparam logic [10:0]        DESC_SPD_U  = 11'(DescendSpeed);
    localparam logic [9:0]         XVEL_RIGHT  = 10'(SwaySpeed);
    localparam logic [9:0]         XVEL_LEFT   = 10'(1024 - SwaySpeed);
    localparam logic [9:0]         YVEL_DOWN   = 10'(DescendSpeed);

    state_t      state_q, state_d;
    state_t      dir_q, dir_d;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  xvel_q, xvel_d;
    logic [9:0]  yvel_q, yvel_d;
    logic [9:0]  xoff_q, xoff_d;
    logic [9:0]  yoff_q, yoff_d;
    logic        bottom_q, bottom_d;

    // Limit checks are done one bit wider so a step past the bound cannot wrap.
    logic signed [10:0] xoff_ext_s;
    logic signed [10:0] x_right_s;
    logic signed [10:0] x_left_s;
    logic [10:0]        y_next_s;

    assign xoff_ext_s = {xoff_q[9], xoff_q};
    assign x_right_s  = xoff_ext_s + SWAY_S;
    assign x_left_s   = xoff_ext_s - SWAY_S;
    assign y_next_s   = {1'b0, yoff_q} + DESC_SPD_U;

    // Next-state and next-output logic; velocities default to zero every frame.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        xvel_d   = 10'd0;
        yvel_d   = 10'd0;
        xoff_d   = xoff_q;
        yoff_d   = yoff_q;
        bottom_d = bottom_q;
        if (enable_i) begin
            case (state_q)
                ST_START: begin
                    if (cnt_q == START_LAST) begin
                        state_d = ST_RIGHT;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_RIGHT: begin
                    if (x_right_s <= XLIM_POS_S) begin
                        xvel_d = XVEL_RIGHT;
                        xoff_d = x_right_s[9:0];
                    end else begin
                        dir_d   = ST_LEFT;
                        cnt_d   = 16'd0;
                        state_d = ST_DOWN;
                    end
                end
                ST_LEFT: begin
                    if (x_left_s >= XLIM_NEG_S) begin
                        xvel_d = XVEL_LEFT;
                        xoff_d = x_left_s[9:0];
                    end else begin
                        dir_d   = ST_RIGHT;
                        cnt_d   = 16'd0;
                        state_d = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (cnt_q == DESC_LAST) begin
                        state_d = dir_q;
                    end else if (y_next_s > YLIM_U) begin
                        bottom_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        yvel_d = YVEL_DOWN;
                        yoff_d = y_next_s[9:0];
                        cnt_d  = cnt_q + 16'd1;
                    end
                end
                ST_HALT: begin
                    bottom_d = 1'b1;
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge frame_clk_i) begin
        if (reset_i) begin
            state_q  <= ST_START;
            dir_q    <= ST_LEFT;
            cnt_q    <= 16'd0;
            xvel_q   <= 10'd0;
            yvel_q   <= 10'd0;
            xoff_q   <= 10'd0;
            yoff_q   <= 10'd0;
            bottom_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            xvel_q   <= xvel_d;
            yvel_q   <= yvel_d;
            xoff_q   <= xoff_d;
            yoff_q   <= yoff_d;
            bottom_q <= bottom_d;
        end
    end

    assign xvel_o   = xvel_q;
    assign yvel_o   = yvel_q;
    assign xoff_o   = xoff_q;
    assign yoff_o   = yoff_q;
    assign state_o  = state_q;
    assign bottom_o = bottom_q;

endmodule

// File: doc/formation_motion_ctrl.md
Name: formation_motion_ctrl

Overview:
- Generates the per-frame formation velocity consumed by the enemy position block (its xvel_i/yvel_i inputs). It sits directly upstream of that block and runs on the same frame clock.
- Produces the classic formation pattern: idle start delay, then sway right, step down, sway left, step down, and so on.
- Stops the formation and flags bottom_o once the vertical limit would be exceeded.
- Tracks its own cumulative offset, which is exported for the collision and game-state logic.

Parameters:
- StartDelay, 60: frames spent in START before the first sway (≥1).
- SwaySpeed, 1: pixels per frame of horizontal motion (1..31).
- XLimit, 40: max |horizontal offset| from home (1..255).
- DescendFrames, 8: frames per downward step (≥1).
- DescendSpeed, 1: pixels per frame while descending (1..31).
- YLimit, 160: max downward offset from home (≤511).

Ports:
- frame_clk_i  in  1  frame clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  1 = advance motion this frame; 0 = pause.
- xvel_o  out  10  horizontal velocity, two's complement (left = 1024-SwaySpeed).
- yvel_o  out  10  vertical velocity, unsigned (always 0 or DescendSpeed).
- xoff_o  out  10  signed cumulative horizontal offset (sum of emitted xvel_o).
- yoff_o  out  10  unsigned cumulative vertical offset.
- state_o  out  3  START=0, RIGHT=1, LEFT=2, DOWN=3, HALT=4.
- bottom_o  out  1  sticky flag, set on entry to HALT.

Behaviour:
- Clocking and reset:
  - One clock (frame_clk_i). Reset is synchronous and active-high (reset_i), sampled at the rising edge.
  - Reset has priority over everything else, including mid-sway or mid-descent.
  - Reset values: state START, internal cnt=0, dir=LEFT, xvel_o=0, yvel_o=0, xoff_o=0, yoff_o=0, bottom_o=0.
- Registering: all outputs are registered. The velocity emitted in a cycle is already included in xoff_o/yoff_o in that same cycle.
- Width rules:
  - Bound checks are evaluated in 11-bit signed arithmetic, so there is no wrap.
  - xoff_o never leaves [-XLimit, +XLimit]; yoff_o never exceeds YLimit.
- Pause: enable_i=0 (any state except reset) forces xvel_o=0 and yvel_o=0 that cycle. State, cnt, dir and offsets are frozen.
- START (enable_i=1):
  - If cnt==StartDelay-1: go to RIGHT, cnt<=0.
  - Otherwise cnt++.
  - Velocities are 0 throughout.
- RIGHT (enable_i=1):
  - If xoff_o+SwaySpeed ≤ XLimit: xvel_o<=SwaySpeed, xoff_o+=SwaySpeed.
  - Otherwise: xvel_o<=0, dir<=LEFT, cnt<=0, go to DOWN.
- LEFT (enable_i=1):
  - If xoff_o-SwaySpeed ≥ -XLimit: xvel_o<=-SwaySpeed, xoff_o-=SwaySpeed.
  - Otherwise: xvel_o<=0, dir<=RIGHT, cnt<=0, go to DOWN.
- DOWN (enable_i=1), priority in this order:
  - If cnt==DescendFrames: yvel_o<=0, go to dir.
  - Else if yoff_o+DescendSpeed > YLimit: yvel_o<=0, bottom_o<=1, go to HALT.
  - Else: yvel_o<=DescendSpeed, yoff_o+=DescendSpeed, cnt++.
  - xvel_o=0 throughout.
- HALT: velocities 0; offsets held; bottom_o=1; exit only via reset.
- Exclusivity: xvel_o and yvel_o are never both nonzero in the same cycle.
- Reversal cost: each reversal has exactly one zero-velocity frame before descent and one after.

Test Plan (overrides StartDelay=2, SwaySpeed=2, XLimit=4, DescendFrames=2, DescendSpeed=3, YLimit=12; enable_i=1 unless stated):
- Reset, then 2 edges -> state START, then RIGHT; xvel_o=0, xoff_o=0.
- Next 3 edges -> xvel_o=2,2,0; xoff_o=2,4,4; state DOWN after the 3rd edge.
- Next 3 edges -> yvel_o=3,3,0; yoff_o=3,6,6; state LEFT. Next 5 edges -> xvel_o=0x3FE ×4, then 0; xoff_o=-4 (0x3FC); state DOWN.
- Continue the pattern: second descent gives yoff_o=12. After the RIGHT sway, a descent attempt (15>12) -> state HALT, bottom_o=1, yoff_o=12, velocities 0 forever.
- Drop enable_i for 5 edges mid-RIGHT at xoff_o=2 -> xvel_o=0, xoff_o=2, state RIGHT held. On re-enable, resume with xvel_o=2.
- Assert reset_i in DOWN with cnt=1 -> next edge: state START, all outputs 0, bottom_o=0. Reset in HALT clears bottom_o.
